// File: rtl/sonar_pkg.sv
// sonar_pkg: state encoding (also driven on db_state) and default sensor timing.
package sonar_pkg;
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIG      = 4'd1,
        ST_WAIT_ECHO = 4'd2,
        ST_MEASURE   = 4'd3,
        ST_EVAL      = 4'd4,
        ST_HOLDOFF   = 4'd5,
        ST_DONE      = 4'd6
    } state_t;
    localparam int DEF_CLK_HZ   = 50_000_000;
    localparam int TRIG_US      = 10;
    localparam int ECHO_WAIT_US = 2_000;
    localparam int ECHO_MAX_US  = 30_000;
    localparam int HOLDOFF_US   = 60_000;
    // Echo is a round trip, so one centimetre of range is 1/17000 s of echo.
    localparam int HALF_SOUND_CM_PER_S = 17_000;
    localparam int CM_MAX = 511;
    function automatic int us_to_cyc(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction
endpackage

// File: rtl/sonar_echo_meter.sv
// sonar_echo_meter: converts echo-high cycles to centimetres, saturating at 511.
// Define SONAR_SCHED_ROUND_EN to round up once the remainder reaches half a centimetre.
module sonar_echo_meter
    import sonar_pkg::*;
#(
    parameter int CYC_PER_CM = 2941
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       count_i,
    output logic [8:0] cm_o
);
    localparam int RW = $clog2(CYC_PER_CM + 1);
    logic [8:0]    cm_q, cm_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          wrap;
    always_comb begin
        wrap  = rem_q == RW'(CYC_PER_CM - 1);
        rem_d = clear_i ? '0 : !count_i ? rem_q : wrap ? '0 : rem_q + 1'b1;
        cm_d  = clear_i ? '0 : (count_i && wrap && cm_q != 9'(CM_MAX)) ? cm_q + 1'b1 : cm_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cm_q  <= '0;
            rem_q <= '0;
        end else begin
            cm_q  <= cm_d;
            rem_q <= rem_d;
        end
    end
`ifdef SONAR_SCHED_ROUND_EN
    assign cm_o = (rem_q >= RW'(CYC_PER_CM / 2) && cm_q != 9'(CM_MAX)) ? cm_q + 1'b1 : cm_q;
`else
    assign cm_o = cm_q;
`endif
endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: triggers an ultrasonic sensor, measures echoes and reports N_MATCH in-window readings.
// Optional SONAR_SCHED_ROUND_EN (in sonar_echo_meter) rounds distances instead of truncating.
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int TRIG_CYC      = us_to_cyc(CLK_HZ, TRIG_US),
    parameter int CYC_PER_CM    = CLK_HZ / HALF_SOUND_CM_PER_S,
    parameter int ECHO_WAIT_CYC = us_to_cyc(CLK_HZ, ECHO_WAIT_US),
    parameter int ECHO_MAX_CYC  = us_to_cyc(CLK_HZ, ECHO_MAX_US),
    parameter int HOLDOFF_CYC   = us_to_cyc(CLK_HZ, HOLDOFF_US),
    parameter int N_MATCH       = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] target_cm,
    input  logic [3:0] tol_cm,
    input  logic       echo,
    output logic       trigger,
    output logic [8:0] distance_cm,
    output logic       meas_valid,
    output logic       timeout_err,
    output logic [2:0] match_cnt,
    output logic       done,
    output logic [3:0] db_state
);
    state_t      state_q;
    logic [31:0] cnt_q;
    logic        armed_q, trig_q, valid_q, tmo_q, done_q;
    logic [8:0]  tgt_q, dist_q;
    logic [3:0]  tol_q;
    logic [2:0]  match_q;
    logic [8:0]  cm;
    logic [9:0]  diff;
    logic [2:0]  match_nx;
    logic        meter_clr, meter_cnt;

    // The rising-edge sample in WAIT_ECHO is part of the echo, so it is counted too.
    assign meter_clr = state_q == ST_TRIG;
    assign meter_cnt = echo && ((state_q == ST_WAIT_ECHO && armed_q) || state_q == ST_MEASURE);
    assign diff      = cm >= tgt_q ? {1'b0, cm} - {1'b0, tgt_q} : {1'b0, tgt_q} - {1'b0, cm};
    assign match_nx  = diff <= {6'd0, tol_q} ? match_q + 1'b1 : 3'd0;

    sonar_echo_meter #(.CYC_PER_CM(CYC_PER_CM)) u_meter (
        .clk_i  (clock),
        .rst_i  (reset),
        .clear_i(meter_clr),
        .count_i(meter_cnt),
        .cm_o   (cm)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
            tgt_q   <= '0;
            tol_q   <= '0;
            dist_q  <= '0;
            match_q <= '0;
        end else begin
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_TRIG;
                    trig_q  <= 1'b1;
                    cnt_q   <= '0;
                    tgt_q   <= target_cm;
                    tol_q   <= tol_cm;
                    match_q <= '0;
                end
                ST_TRIG: if (cnt_q == 32'(TRIG_CYC - 1)) begin
                    state_q <= start ? ST_WAIT_ECHO : ST_IDLE;
                    trig_q  <= 1'b0;
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                end
                ST_WAIT_ECHO: begin
                    // An echo still high from before must drop before a rise is accepted.
                    armed_q <= armed_q | !echo;
                    if (echo && armed_q) begin
                        state_q <= start ? ST_MEASURE : ST_IDLE;
                        cnt_q   <= 32'd1;
                    end else if (cnt_q == 32'(ECHO_WAIT_CYC - 1)) begin
                        state_q <= start ? ST_HOLDOFF : ST_IDLE;
                        cnt_q   <= '0;
                        tmo_q   <= start;
                        match_q <= '0;
                    end
                end
                ST_MEASURE: if (!echo) begin
                    state_q <= start ? ST_EVAL : ST_IDLE;
                end else if (cnt_q == 32'(ECHO_MAX_CYC)) begin
                    state_q <= start ? ST_HOLDOFF : ST_IDLE;
                    cnt_q   <= '0;
                    tmo_q   <= start;
                    match_q <= '0;
                end
                ST_EVAL: begin
                    dist_q  <= cm;
                    valid_q <= 1'b1;
                    match_q <= match_nx;
                    cnt_q   <= '0;
                    done_q  <= start && match_nx == 3'(N_MATCH);
                    state_q <= !start ? ST_IDLE : match_nx == 3'(N_MATCH) ? ST_DONE : ST_HOLDOFF;
                end
                ST_HOLDOFF: if (cnt_q == 32'(HOLDOFF_CYC - 1)) begin
                    state_q <= start ? ST_TRIG : ST_IDLE;
                    trig_q  <= start;
                    cnt_q   <= '0;
                end
                ST_DONE: if (!start) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign trigger     = trig_q;
    assign distance_cm = dist_q;
    assign meas_valid  = valid_q;
    assign timeout_err = tmo_q;
    assign match_cnt   = match_q;
    assign done        = done_q;
    assign db_state    = state_q;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: randomized echo sessions checked against a distance/match model.
module tb_sonar_scheduler;
    localparam int TRIG_CYC = 4, CPC = 8, WAIT_CYC = 30, MAX_CYC = 5000, HOLD_CYC = 12, NM = 3;
    logic       clock = 1'b0, reset = 1'b1, start = 1'b0, echo = 1'b0;
    logic [8:0] target_cm = '0;
    logic [3:0] tol_cm = '0;
    logic       trigger, meas_valid, timeout_err, done;
    logic [8:0] distance_cm;
    logic [2:0] match_cnt;
    logic [3:0] db_state;
    int total = 0, bad = 0;
    int cyc = 0, n_rise = 0, n_fall = 0, nv = 0, nt = 0, rise_cyc = 0, fall_cyc = 0, ev_cyc = 0;
    int ev_dist = 0, ev_match = 0, ev_done = 0;
    logic trig_prev = 1'b0;
    int m_tgt = 0, m_tol = 0, m_match = 0, m_dist = 0;

    sonar_scheduler #(
        .CLK_HZ(1_000_000), .TRIG_CYC(TRIG_CYC), .CYC_PER_CM(CPC), .ECHO_WAIT_CYC(WAIT_CYC),
        .ECHO_MAX_CYC(MAX_CYC), .HOLDOFF_CYC(HOLD_CYC), .N_MATCH(NM)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .target_cm(target_cm), .tol_cm(tol_cm),
        .echo(echo), .trigger(trigger), .distance_cm(distance_cm), .meas_valid(meas_valid),
        .timeout_err(timeout_err), .match_cnt(match_cnt), .done(done), .db_state(db_state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        trig_prev <= trigger;
        if (trigger && !trig_prev) begin
            n_rise   <= n_rise + 1;
            rise_cyc <= cyc;
        end
        if (!trigger && trig_prev) begin
            n_fall   <= n_fall + 1;
            fall_cyc <= cyc;
        end
        if (meas_valid || timeout_err) begin
            nv       <= nv + int'(meas_valid);
            nt       <= nt + int'(timeout_err);
            ev_cyc   <= cyc;
            ev_dist  <= int'(distance_cm);
            ev_match <= int'(match_cnt);
            ev_done  <= int'(done);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_cm(input int len);
        int c = len / CPC;
`ifdef SONAR_SCHED_ROUND_EN
        if (len % CPC >= CPC / 2) c++;
`endif
        return c > 511 ? 511 : c;
    endfunction

    task automatic wait_trigger(input bit after_ev, input bit pre_high);
        int r0 = n_rise, f0 = n_fall, k = 0;
        while (n_rise == r0 && k < 200) begin
            tick();
            k++;
        end
        chk("trig_seen", int'(n_rise != r0), 1);
        if (after_ev) chk("holdoff", rise_cyc - ev_cyc, HOLD_CYC);
        if (pre_high) echo = 1'b1;
        k = 0;
        while (n_fall == f0 && k < 50) begin
            tick();
            k++;
        end
        chk("trig_width", fall_cyc - rise_cyc, TRIG_CYC);
    endtask

    // kind: 0 normal echo, 1 no echo, 2 echo already high when waiting starts
    task automatic do_meas(input int kind, input int len, input int delay, input bit after_ev);
        int v0 = nv, t0 = nt, k = 0;
        bit exp_to;
        wait_trigger(after_ev, kind == 2);
        if (kind == 2) begin
            repeat (3) tick();
            echo = 1'b0;
        end
        if (kind != 1) begin
            repeat (delay) tick();
            echo = 1'b1;
            repeat (len) tick();
            echo = 1'b0;
        end
        while (nv == v0 && nt == t0 && k < WAIT_CYC + 20) begin
            tick();
            k++;
        end
        exp_to = kind == 1 || len > MAX_CYC;
        chk("timeout_pulses", nt - t0, int'(exp_to));
        chk("valid_pulses", nv - v0, int'(!exp_to));
        if (kind == 1) chk("wait_timeout_cyc", ev_cyc - fall_cyc, WAIT_CYC);
        if (exp_to) m_match = 0;
        else begin
            m_dist  = exp_cm(len);
            m_match = ((m_dist > m_tgt ? m_dist - m_tgt : m_tgt - m_dist) <= m_tol) ? m_match + 1 : 0;
        end
        chk("distance", ev_dist, m_dist);
        chk("match_cnt", ev_match, m_match);
        chk("done_at_event", ev_done, int'(m_match == NM));
    endtask

    initial begin
        int v0, r0, k;
        repeat (3) tick();
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_dist", int'(distance_cm), 0);
        chk("rst_match", int'(match_cnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(db_state), 0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_no_start", int'(db_state), 0);
        for (int s = 0; s < 5; s++) begin
            m_tgt = $urandom_range(10, 60);
            m_tol = $urandom_range(0, 3);
            m_match = 0;
            target_cm = 9'(m_tgt);
            tol_cm = 4'(m_tol);
            start = 1'b1;
            for (int i = 0; i < 10 && m_match < NM; i++) begin
                int kind, len, c;
                kind = (s == 0 && i < 3) ? i : 0;
                c = m_tgt + $urandom_range(0, 2 * m_tol + 2) - m_tol - 1;
                len = c * CPC + $urandom_range(0, CPC - 1);
                if (s == 0 && i == 3) len = MAX_CYC + 5;
                if (s == 1 && i == 0) len = 4200;
                do_meas(kind, len, $urandom_range(0, 10), i > 0);
            end
            if (m_match == NM) begin
                r0 = n_rise;
                repeat (2 * HOLD_CYC) tick();
                chk("done_hold", int'(done), 1);
                chk("done_state", int'(db_state), 6);
                chk("done_dist", int'(distance_cm), m_dist);
                chk("done_no_trig", n_rise - r0, 0);
                start = 1'b0;
                tick();
                chk("done_clear", int'(done), 0);
                chk("done_to_idle", int'(db_state), 0);
            end else begin
                start = 1'b0;
                k = 0;
                while (db_state != 4'd0 && k < 40) begin
                    tick();
                    k++;
                end
                chk("stop_idle", int'(db_state), 0);
            end
        end
        target_cm = 9'd30;
        tol_cm = 4'd0;
        start = 1'b1;
        v0 = nv;
        wait_trigger(1'b0, 1'b0);
        echo = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        repeat (10) tick();
        echo = 1'b0;
        repeat (3) tick();
        chk("drop_idle", int'(db_state), 0);
        chk("drop_no_valid", nv - v0, 0);
        start = 1'b1;
        wait_trigger(1'b0, 1'b0);
        echo = 1'b1;
        repeat (5) tick();
        chk("in_measure", int'(db_state), 3);
        reset = 1'b1;
        tick();
        chk("rst_meas_trigger", int'(trigger), 0);
        chk("rst_meas_state", int'(db_state), 0);
        chk("rst_meas_match", int'(match_cnt), 0);
        chk("rst_meas_dist", int'(distance_cm), 0);
        v0 = nv;
        echo = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_meas_no_valid", nv - v0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
